// File: rtl/pri_vec_decoder.sv
// Purpose : rebuilds a 16-bit request vector from a stream of 8-bit priority-encoder words, OR-accumulated per frame.
// Latency : closing word accepted at edge N -> out_valid and final vec_out visible after edge N.
// Backpr. : in_ready low while a result is held; result held stable until out_valid && out_ready (1-cycle bubble per frame).
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   code_in/in_valid/in_last     encoded word stream (index, EMPTY_CODE, or illegal)
//   acc_en                       1 = accumulate until in_last, 0 = each word is its own frame
//   in_ready                     word can be accepted this cycle
//   vec_out/cnt_out/err_out/dup_out, out_valid/out_ready   frame result handshake
module pri_vec_decoder #(
  parameter int         IDX_W      = 4,
  parameter logic [7:0] EMPTY_CODE = 8'hF0,
  parameter int         CNT_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              code_in,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    acc_en,
  output logic [(2**IDX_W)-1:0]   vec_out,
  output logic [CNT_W-1:0]        cnt_out,
  output logic                    err_out,
  output logic                    dup_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int VEC_W = 2**IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               dup_q, dup_d;

  logic               accept;
  logic               code_is_idx;
  logic [IDX_W-1:0]   idx;

  // in_ready depends only on registered state (and reset), never on in_valid.
  assign in_ready    = (state_q != HOLD) && !rst;
  assign accept      = in_valid && in_ready;
  // A legal index has all bits above the index field clear.
  assign code_is_idx = (code_in[7:IDX_W] == '0);
  assign idx         = code_in[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    dup_d   = dup_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (code_is_idx) begin
            if (acc_q[idx]) dup_d = 1'b1;
            acc_d[idx] = 1'b1;
          end else if (code_in != EMPTY_CODE) begin
            err_d = 1'b1;
          end
          // Saturate rather than wrap so long frames still report "many".
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          state_d = (in_last || !acc_en) ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          dup_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dup_q   <= dup_d;
    end
  end

  // Outside HOLD the vector output simply shows the running accumulator.
  assign vec_out   = acc_q;
  assign cnt_out   = cnt_q;
  assign err_out   = err_q;
  assign dup_out   = dup_q;
  assign out_valid = (state_q == HOLD);

endmodule
